la_wb_master: RTL

Wishbone classic (B4, non-pipelined) bus master that turns single-word commands from a valid/ready command port into one Wishbone read or write cycle each. It returns the read data or a timeout error on a valid/ready response port. It is the initiator counterpart to the user-project Wishbone slave. It lets logic-analyzer or test-sequencer logic drive that slave directly, for bring-up and self-test, without the management SoC.

---
 rtl/la_wb_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/la_wb_master.sv
// la_wb_master
// Wishbone classic (B4, non-pipelined) bus master. Each command accepted on
// the valid/ready command port becomes one Wishbone read or write cycle. The
// result (read data, or a timeout error) is returned on a valid/ready
// response port. Only one transaction is outstanding at a time.
//
// Ports
//   wb_clk_i, wb_rst_ni           clock, async-assert active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i          command fields (latched on accept)
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_dat_o, rsp_err_o          read data (0 for writes/errors), timeout flag
//   wbm_cyc_o, wbm_stb_o, wbm_we_o,
//   wbm_adr_o, wbm_dat_o, wbm_sel_o  Wishbone master outputs (all registered)
//   wbm_ack_i, wbm_dat_i          Wishbone slave acknowledge and read data
module la_wb_master #(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [AW-1:0]     cmd_adr_i,
  input  logic [DW-1:0]     cmd_dat_i,
  input  logic [DW/8-1:0]   cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DW-1:0]     rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  output logic [DW/8-1:0]   wbm_sel_o,
  input  logic              wbm_ack_i,
  input  logic [DW-1:0]     wbm_dat_i
);

  // Counter wide enough to hold TIMEOUT, never narrower than one bit.
  localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_ack;
  logic              w_tout;

  logic [CW-1:0]     r_cnt;
  logic              r_cmd_ready;
  logic              r_cyc;
  logic              r_we;
  logic [AW-1:0]     r_adr;
  logic [DW-1:0]     r_dat;
  logic [DW/8-1:0]   r_sel;
  logic              r_rsp_valid;
  logic [DW-1:0]     r_rsp_dat;
  logic              r_rsp_err;

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_ack        = 1'b0;
    w_tout       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid_i && r_cmd_ready) begin
          w_accept     = 1'b1;
          w_state_next = S_BUS;
        end
      end
      S_BUS: begin
        if (wbm_ack_i) begin
          w_ack        = 1'b1;
          w_state_next = S_RESP;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          // Counter value k at a BUS edge means k+1 bus cycles have elapsed,
          // so aborting at TIMEOUT-1 keeps cyc/stb up for exactly TIMEOUT.
          w_tout       = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs. Handshake/strobe flags are computed
  // from the next state so each output is a flop, not a state decode.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_next == S_IDLE);
      r_cyc       <= (w_state_next == S_BUS);
      r_rsp_valid <= (w_state_next == S_RESP);

      if (w_accept) begin
        r_we  <= cmd_we_i;
        r_adr <= cmd_adr_i;
        r_dat <= cmd_dat_i;
        r_sel <= cmd_sel_i;
        r_cnt <= '0;
      end else if (r_state == S_BUS && !w_ack && !w_tout) begin
        // Saturate rather than wrap; only matters when TIMEOUT is 0.
        if (r_cnt != {CW{1'b1}}) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      if (w_ack) begin
        r_rsp_dat <= r_we ? '0 : wbm_dat_i;
        r_rsp_err <= 1'b0;
      end else if (w_tout) begin
        r_rsp_dat <= '0;
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign wbm_sel_o   = r_sel;

endmodule
